// File: rtl/xb_gpio_in_debounce_pkg.sv
// Shared constants for the XB GPIO input conditioning stage.
//   XB_GPIO_WIDTH        default number of GPIO bits
//   XB_GPIO_RESET_VALUE  default reset word for data_out and sample state
//   cnt_width()          prescaler counter width, at least 1 bit even for DIV=1
package xb_gpio_pkg;

   localparam int XB_GPIO_WIDTH = 32;
   localparam logic [XB_GPIO_WIDTH-1:0] XB_GPIO_RESET_VALUE = '0;

   function automatic int cnt_width(input int div);
      return (div > 1) ? $clog2(div) : 1;
   endfunction

endpackage

// File: rtl/xb_gpio_in_debounce_if.sv
// Signal bundle between the XB pins and the GPIO slave in_port.
//   pins_in      raw asynchronous pin levels      (master -> slave)
//   bypass       skip debouncing                  (master -> slave)
//   data_out     debounced word                   (slave -> master)
//   change       one-cycle change pulse           (slave -> master)
//   change_mask  bits that changed with the pulse (slave -> master)
//   tick         sample-tick strobe               (slave -> master)
interface xb_gpio_in_debounce_if
   import xb_gpio_pkg::*;
#(
   parameter int WIDTH = XB_GPIO_WIDTH
);

   logic [WIDTH-1:0] pins_in;
   logic             bypass;
   logic [WIDTH-1:0] data_out;
   logic             change;
   logic [WIDTH-1:0] change_mask;
   logic             tick;

   modport slave (
      input  pins_in,
      input  bypass,
      output data_out,
      output change,
      output change_mask,
      output tick
   );

   modport master (
      output pins_in,
      output bypass,
      input  data_out,
      input  change,
      input  change_mask,
      input  tick
   );

endinterface

// File: rtl/xb_gpio_debounce_bit.sv
// Per-bit conditioning cell: synchroniser, tick-sampled history and
// agreement-based acceptance.
//   clk, reset_n  clock and async active-low reset
//   tick          shared sample strobe
//   bypass        pass synchronised level straight to level
//   pin           raw asynchronous pin
//   level         debounced level (registered)
//   flip          level changes on the coming edge (combinational)
module xb_gpio_debounce_bit #(
   parameter int   SYNC_STAGES = 2,
   parameter int   DEPTH       = 4,
   parameter logic RESET_BIT   = 1'b0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic tick,
   input  logic bypass,
   input  logic pin,
   output logic level,
   output logic flip
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync;
   logic [DEPTH-2:0]       hist;
   logic [DEPTH-2:0]       hist_nxt;
   logic [DEPTH-1:0]       win;
   logic                   level_nxt;

   assign sync = sync_q[SYNC_STAGES-1];
   assign win  = {hist, sync};

   always_comb begin
      level_nxt = level;
      hist_nxt  = hist;
      if (bypass) begin
         // Preload the history so that leaving bypass sees a settled window.
         level_nxt = sync;
         hist_nxt  = {(DEPTH-1){sync}};
      end else if (tick) begin
         if ((&win) || (~|win)) begin
            level_nxt = sync;
         end
         hist_nxt = win[DEPTH-2:0];
      end
   end

   assign flip = level_nxt ^ level;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= {SYNC_STAGES{RESET_BIT}};
         hist   <= {(DEPTH-1){RESET_BIT}};
         level  <= RESET_BIT;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
         hist   <= hist_nxt;
         level  <= level_nxt;
      end
   end

endmodule

// File: rtl/xb_gpio_in_debounce.sv
// XB GPIO input conditioning stage feeding the GPIO slave in_port.
//   clk, reset_n  clock and async active-low reset
//   bus           xb_gpio_in_debounce_if slave side:
//                 pins_in, bypass in; data_out, change, change_mask, tick out
// Owns the shared sample prescaler and the change/mask registers; the
// per-bit cells do synchronisation and debouncing.
module xb_gpio_in_debounce
   import xb_gpio_pkg::*;
#(
   parameter int               WIDTH       = XB_GPIO_WIDTH,
   parameter int               SYNC_STAGES = 2,
   parameter int               DIV         = 1000,
   parameter int               DEPTH       = 4,
   parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(XB_GPIO_RESET_VALUE)
) (
   input  logic                 clk,
   input  logic                 reset_n,
   xb_gpio_in_debounce_if.slave bus
);

   localparam int            CW       = cnt_width(DIV);
   localparam logic [CW-1:0] CNT_LOAD = CW'(DIV - 1);

   // Down-counter: reloads to DIV-1, tick at terminal count 0. With DIV=1
   // the load value is 0, so tick stays high permanently.
   logic [CW-1:0]    cnt_rem;
   logic             tick_w;
   logic [WIDTH-1:0] level_w;
   logic [WIDTH-1:0] flip_w;
   logic             change_q;
   logic [WIDTH-1:0] mask_q;

   assign tick_w = (cnt_rem == '0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_rem <= CNT_LOAD;
      end else if (tick_w) begin
         cnt_rem <= CNT_LOAD;
      end else begin
         cnt_rem <= cnt_rem - CW'(1);
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      xb_gpio_debounce_bit #(
         .SYNC_STAGES (SYNC_STAGES),
         .DEPTH       (DEPTH),
         .RESET_BIT   (RESET_VALUE[i])
      ) u_bit (
         .clk     (clk),
         .reset_n (reset_n),
         .tick    (tick_w),
         .bypass  (bus.bypass),
         .pin     (bus.pins_in[i]),
         .level   (level_w[i]),
         .flip    (flip_w[i])
      );
   end

   // flip_w is old^new for the edge about to happen, so registering it here
   // lines change/change_mask up with the new data_out.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         change_q <= 1'b0;
         mask_q   <= '0;
      end else begin
         change_q <= |flip_w;
         mask_q   <= flip_w;
      end
   end

   assign bus.data_out    = level_w;
   assign bus.change      = change_q;
   assign bus.change_mask = mask_q;
   assign bus.tick        = tick_w;

endmodule

// File: tb/tb_xb_gpio_in_debounce.sv
module tb_xb_gpio_in_debounce;

   localparam int WIDTH = 32;
   localparam int SYNC  = 2;
   localparam int DIV   = 4;
   localparam int DEPTH = 3;

   logic clk = 1'b0;
   logic reset_n;

   always #5 clk = ~clk;

   xb_gpio_in_debounce_if #(.WIDTH(WIDTH)) bus_if ();

   xb_gpio_in_debounce #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC),
      .DIV         (DIV),
      .DEPTH       (DEPTH),
      .RESET_VALUE ('0)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus_if)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic check_val(input string tag, input logic [WIDTH-1:0] got,
                            input logic [WIDTH-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: pins reach the debouncer through a SYNC-deep delay
   // line; each sample tick (every DIV-th edge since reset) appends one
   // sample; a bit takes a new level when the last DEPTH samples agree.
   logic [WIDTH-1:0] pq[$];
   logic [WIDTH-1:0] smp[$];
   int unsigned      e;
   logic [WIDTH-1:0] exp_data, exp_mask;
   logic             exp_change, exp_tick;

   int               pulses;
   logic [WIDTH-1:0] last_mask;

   task automatic model_reset();
      pq.delete();
      smp.delete();
      repeat (SYNC) pq.push_back('0);
      repeat (DEPTH - 1) smp.push_back('0);
      e          = 0;
      exp_data   = '0;
      exp_mask   = '0;
      exp_change = 1'b0;
      exp_tick   = ((1 % DIV) == 0);
   endtask

   task automatic model_edge(input logic [WIDTH-1:0] p, input logic byp);
      logic [WIDTH-1:0] s, old, nw, ones, anyv;
      s = pq.pop_front();
      pq.push_back(p);
      e++;
      old = exp_data;
      nw  = old;
      if (byp) begin
         nw = s;
         foreach (smp[k]) smp[k] = s;
      end else if ((e % DIV) == 0) begin
         ones = s;
         anyv = s;
         foreach (smp[k]) begin
            ones &= smp[k];
            anyv |= smp[k];
         end
         nw = ones | (old & anyv);
         smp.push_back(s);
         void'(smp.pop_front());
      end
      exp_mask   = old ^ nw;
      exp_change = |exp_mask;
      exp_data   = nw;
      exp_tick   = (((e + 1) % DIV) == 0);
   endtask

   task automatic check_all(input string pfx);
      check_val({pfx, "_data"}, bus_if.data_out, exp_data);
      check_val({pfx, "_chg"}, WIDTH'(bus_if.change), WIDTH'(exp_change));
      check_val({pfx, "_mask"}, bus_if.change_mask, exp_mask);
      check_val({pfx, "_tick"}, WIDTH'(bus_if.tick), WIDTH'(exp_tick));
   endtask

   // One clock: starts and ends at a falling edge.
   task automatic cyc(input logic [WIDTH-1:0] p, input logic byp);
      bus_if.pins_in = p;
      bus_if.bypass  = byp;
      @(posedge clk);
      model_edge(p, byp);
      #1;
      check_all("cyc");
      if (bus_if.change) begin
         pulses++;
         last_mask = bus_if.change_mask;
      end
      @(negedge clk);
   endtask

   task automatic do_reset(input int hold);
      reset_n = 1'b0;
      #1;
      model_reset();
      check_all("rst");
      repeat (hold) @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic hold_and_count(input logic [WIDTH-1:0] p, input logic byp, input int n);
      pulses    = 0;
      last_mask = '0;
      repeat (n) cyc(p, byp);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout n_cmp=%0d", n_cmp);
      $fatal(1, "timeout");
   end

   initial begin
      logic [WIDTH-1:0] p, g;
      logic             b;

      reset_n        = 1'b0;
      bus_if.pins_in = '0;
      bus_if.bypass  = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      check_all("por");
      reset_n = 1'b1;

      // Tick cadence: high in cycles 3, 7, 11 after release.
      check_val("tick_c0", WIDTH'(bus_if.tick), '0);
      for (int c = 1; c <= 11; c++) begin
         cyc('0, 1'b0);
         check_val($sformatf("tick_c%0d", c), WIDTH'(bus_if.tick),
                   WIDTH'((c == 3) || (c == 7) || (c == 11)));
      end

      // Clean step up and down on bit 0.
      hold_and_count(32'h1, 1'b0, 20);
      check_val("step_up_pulses", WIDTH'(pulses), 32'd1);
      check_val("step_up_mask", last_mask, 32'h1);
      check_val("step_up_data", bus_if.data_out, 32'h1);
      hold_and_count(32'h0, 1'b0, 20);
      check_val("step_dn_pulses", WIDTH'(pulses), 32'd1);
      check_val("step_dn_mask", last_mask, 32'h1);
      check_val("step_dn_data", bus_if.data_out, 32'h0);

      // Glitch on bit 5 covering exactly two ticks.
      hold_and_count(32'h20, 1'b0, 8);
      repeat (20) cyc('0, 1'b0);
      check_val("glitch_pulses", WIDTH'(pulses), 32'd0);
      check_val("glitch_data", bus_if.data_out, 32'h0);

      // Bits 3 and 31 together.
      hold_and_count(32'h8000_0008, 1'b0, 20);
      check_val("multi_pulses", WIDTH'(pulses), 32'd1);
      check_val("multi_mask", last_mask, 32'h8000_0008);
      check_val("multi_data", bus_if.data_out, 32'h8000_0008);
      hold_and_count(32'h0, 1'b0, 20);
      check_val("multi_dn_pulses", WIDTH'(pulses), 32'd1);

      // Bypass: three clocks pin to data_out, then leave bypass quietly.
      hold_and_count(32'hA5, 1'b1, 2);
      check_val("byp_early", bus_if.data_out, 32'h0);
      cyc(32'hA5, 1'b1);
      check_val("byp_data3", bus_if.data_out, 32'hA5);
      repeat (5) cyc(32'hA5, 1'b1);
      check_val("byp_pulses", WIDTH'(pulses), 32'd1);
      check_val("byp_mask", last_mask, 32'hA5);
      hold_and_count(32'hA5, 1'b0, 20);
      check_val("byp_exit_pulses", WIDTH'(pulses), 32'd0);
      check_val("byp_exit_data", bus_if.data_out, 32'hA5);
      repeat (20) cyc('0, 1'b0);

      // Reset two ticks into a step: restart needs three full ticks.
      repeat (9) cyc(32'h1, 1'b0);
      check_val("mid_pre_data", bus_if.data_out, 32'h0);
      do_reset(3);
      repeat (11) cyc(32'h1, 1'b0);
      check_val("restart_wait", bus_if.data_out, 32'h0);
      cyc(32'h1, 1'b0);
      check_val("restart_data", bus_if.data_out, 32'h1);
      check_val("restart_chg", WIDTH'(bus_if.change), 32'd1);
      repeat (20) cyc('0, 1'b0);

      // Randomized: slow level changes, single-cycle glitches, bypass
      // toggles and one asynchronous reset.
      p = '0;
      b = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 15) == 0)
            p ^= ($urandom_range(0, 3) == 0) ? $urandom() : (32'h1 << $urandom_range(0, 31));
         if ($urandom_range(0, 299) == 0)
            b = ~b;
         g = ($urandom_range(0, 5) == 0) ? (32'h1 << $urandom_range(0, 31)) : '0;
         if (i == 1500)
            do_reset(2);
         cyc(p ^ g, b);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
